serial_frame_rx: RTL and testbench
==================================

# serial_frame_rx

Serial frame receiver for the single-bit `d`/`en` stream used by the latch and flip-flop blocks. It samples `d` on each `en` strobe, detects a start bit, and assembles WIDTH data bits, LSB first. It can also check a parity bit and always checks the stop bit. It presents the word on `q` with a one-cycle `valid` pulse. It is the receiving end of the serial bit stream that the team's stimulus benches and the upstream serializer drive.

## Interface
- WIDTH, 8, number of data bits per frame (1..32)
- PARITY, 0, 0 = no parity bit, 1 = even parity, 2 = odd parity
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high reset; clears all state and outputs
- en  input  1  bit strobe; `d` is sampled only on rising `clk` edges where `en`=1
- d  input  1  serial data line; idles high
- q  output  WIDTH  last correctly received word; held until the next good frame
- valid  output  1  one-cycle pulse: `q` was just updated
- frame_err  output  1  one-cycle pulse: stop bit was sampled as 0
- parity_err  output  1  one-cycle pulse: parity mismatch (PARITY != 0)
- busy  output  1  high while a frame is in progress (state != IDLE)

## Operation
- States:
  - IDLE: waiting for a start bit.
  - DATA: collecting data bits.
  - PAR: collecting the parity bit; present only when PARITY != 0.
  - STOP: checking the stop bit.
- All transitions happen only on edges where `en`=1. With `en`=0 the state, bit counter and shift register hold.
- IDLE: `d`=0 → DATA, bit counter cleared. `d`=1 → stay in IDLE.
- DATA: `d` is written to shift bit [count], LSB first, and count increments.
  - After the WIDTH-th bit, go to PAR if PARITY != 0, else STOP.
- PAR: sample the parity bit into a register, then → STOP.
  - Even parity: XOR of data bits and parity bit must be 0.
  - Odd parity: that XOR must be 1.
- STOP, `d`=1:
  - Parity good (or none): `q` ← shift and `valid` pulses.
  - Parity bad: `parity_err` pulses and `q` holds.
- STOP, `d`=0: `frame_err` pulses and `q` holds. `parity_err` is not asserted.
- STOP always → IDLE.
- Back-to-back frames: the first `en` after the stop bit can be the next start bit. No idle gap is required.
- Bit counter width is clog2(WIDTH+1). It never wraps past WIDTH.
- Reset is asynchronous and may arrive mid-frame. It forces:
  - state → IDLE, counter and shift → 0
  - `q` → 0
  - `valid`, `frame_err`, `parity_err` → 0
  - `busy` → 0 immediately, without waiting for a clock.
- The first frame after reset must start with a fresh start bit. Partial bits from before reset are discarded.

## Timing
- Outputs are registered; there is no combinational path from `d` or `en` to any output.
- `busy` rises on the edge that samples the start bit. It falls on the edge that samples the stop bit.
- `valid`, `frame_err` and `parity_err` are high for exactly the one `clk` cycle after the stop-bit sampling edge, regardless of `en`.
- At most one of `valid`, `frame_err`, `parity_err` is high in any cycle.
- Frame length is 2 + WIDTH + (PARITY != 0) strobes.
- Latency: `q`/`valid` update on the edge sampling the stop bit and are visible the same cycle after that edge.
- `en` may be high continuously (one bit per clock) or sparse (any gap between strobes); the result is identical either way.
- Reset values: `q`=0, `valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0.

## Test plan
- Good frame: WIDTH=8, PARITY=0, `en` held at 1. Send 0, 0xA5 LSB first (1,0,1,0,0,1,0,1), then 1 → `q`=0xA5, `valid` high for exactly one cycle, `busy` high for 9 cycles.
- Framing error: send 0, 0x3C, then stop bit 0 → `frame_err` one-cycle pulse, `valid`=0, `q` keeps its previous value (0xA5).
- Parity, PARITY=1: frame 0x03 with parity bit 0 and stop 1 → `q`=0x03 with `valid`. Same frame with parity bit 1 → `parity_err` pulse, `q` stays 0x03.
- Sparse strobe: `en` high one cycle in four, frame 0x5A → same result as continuous `en`. State holds across `en`=0 cycles.
- Back-to-back: frames 0x11 then 0xEE with no idle bit between them → two `valid` pulses, `q`=0x11 then 0xEE.
- Reset mid-frame: assert `reset` after 3 data bits → `busy`=0 and `q`=0 immediately. Release `reset`, send 0xC3 → `q`=0xC3, `valid` pulses once.

Source files
------------

// File: rtl/serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_rx
// Description : Strobed serial frame receiver: start bit, WIDTH data bits
//               (LSB first), optional parity bit and stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_rx #(
    parameter int WIDTH  = 8,
    parameter int PARITY = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             d,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             frame_err,
    output logic             parity_err,
    output logic             busy
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             par_q, par_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             perr_q, perr_d;
    logic             parity_ok;

    // Even parity wants the XOR of data and parity bit to be 0, odd wants 1.
    always_comb begin
        parity_ok = 1'b1;
        if (PARITY == 1) begin
            parity_ok = ~(^shift_q ^ par_q);
        end else if (PARITY == 2) begin
            parity_ok = ^shift_q ^ par_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        word_d  = word_q;
        par_d   = par_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;

        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (!d) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                        shift_d = '0;
                    end
                end
                ST_DATA: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (cnt_q == CW'(i)) begin
                            shift_d[i] = d;
                        end
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
                    end
                end
                ST_PAR: begin
                    par_d   = d;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (!d) begin
                        ferr_d = 1'b1;
                    end else if (!parity_ok) begin
                        perr_d = 1'b1;
                    end else begin
                        word_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            word_q  <= '0;
            par_q   <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            par_q   <= par_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
        end
    end

    // busy decodes the state flop directly so an async reset clears it at once.
    assign busy       = (state_q != ST_IDLE);
    assign q          = word_q;
    assign valid      = valid_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_frame_rx
// Description : Directed self-checking bench for serial_frame_rx (no parity
//               and even-parity instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       d;
    logic       sel;
    logic       en_a, en_b;
    logic [7:0] q_a, q_b;
    logic       valid_a, ferr_a, perr_a, busy_a;
    logic       valid_b, ferr_b, perr_b, busy_b;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_cnt = 0;
    int valid_cnt = 0;
    int base;

    assign en_a = en & ~sel;
    assign en_b = en & sel;

    always #5 clk = ~clk;

    serial_frame_rx #(.WIDTH(8), .PARITY(0)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .en         (en_a),
        .d          (d),
        .q          (q_a),
        .valid      (valid_a),
        .frame_err  (ferr_a),
        .parity_err (perr_a),
        .busy       (busy_a)
    );

    serial_frame_rx #(.WIDTH(8), .PARITY(1)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .en         (en_b),
        .d          (d),
        .q          (q_b),
        .valid      (valid_b),
        .frame_err  (ferr_b),
        .parity_err (perr_b),
        .busy       (busy_b)
    );

    always @(negedge clk) begin
        if (busy_a) busy_cnt++;
        if (valid_a) valid_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int gap);
        d  = b;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        d  = 1'b1;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns 1 time unit after the edge that samples the stop bit.
    task automatic send_frame(input logic [7:0] w, input logic has_par, input logic pb,
                              input logic stop, input int gap);
        send_bit(1'b0, gap);
        for (int i = 0; i < 8; i++) send_bit(w[i], gap);
        if (has_par) send_bit(pb, gap);
        send_bit(stop, 0);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        d     = 1'b1;
        sel   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_q", 32'(q_a), 32'h0);
        check_eq("rst_valid", 32'(valid_a), 32'h0);
        check_eq("rst_frame_err", 32'(ferr_a), 32'h0);
        check_eq("rst_parity_err", 32'(perr_a), 32'h0);
        check_eq("rst_busy", 32'(busy_a), 32'h0);
        reset = 1'b0;
        idle_cycle();

        // Good frame, continuous strobe
        base = busy_cnt;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 0);
        check_eq("good_q", 32'(q_a), 32'hA5);
        check_eq("good_valid", 32'(valid_a), 32'h1);
        check_eq("good_ferr", 32'(ferr_a), 32'h0);
        check_eq("good_busy_fall", 32'(busy_a), 32'h0);
        idle_cycle();
        check_eq("good_valid_1cyc", 32'(valid_a), 32'h0);
        check_eq("good_busy_cycles", 32'(busy_cnt - base), 32'd9);

        // Framing error keeps previous word
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 0);
        check_eq("ferr_pulse", 32'(ferr_a), 32'h1);
        check_eq("ferr_valid", 32'(valid_a), 32'h0);
        check_eq("ferr_perr", 32'(perr_a), 32'h0);
        check_eq("ferr_q_hold", 32'(q_a), 32'hA5);
        idle_cycle();
        check_eq("ferr_1cyc", 32'(ferr_a), 32'h0);

        // Even parity instance
        sel = 1'b1;
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 0);
        check_eq("par_ok_q", 32'(q_b), 32'h03);
        check_eq("par_ok_valid", 32'(valid_b), 32'h1);
        check_eq("par_ok_perr", 32'(perr_b), 32'h0);
        idle_cycle();
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, 0);
        check_eq("par_bad_perr", 32'(perr_b), 32'h1);
        check_eq("par_bad_valid", 32'(valid_b), 32'h0);
        check_eq("par_bad_q_hold", 32'(q_b), 32'h03);
        idle_cycle();
        check_eq("par_bad_1cyc", 32'(perr_b), 32'h0);
        sel = 1'b0;

        // Sparse strobe, one in four
        base = busy_cnt;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 3);
        check_eq("sparse_q", 32'(q_a), 32'h5A);
        check_eq("sparse_valid", 32'(valid_a), 32'h1);
        check_eq("sparse_busy_cycles", 32'(busy_cnt - base), 32'd36);
        idle_cycle();

        // Back-to-back frames
        base = valid_cnt;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 0);
        check_eq("b2b_q1", 32'(q_a), 32'h11);
        check_eq("b2b_valid1", 32'(valid_a), 32'h1);
        send_frame(8'hEE, 1'b0, 1'b0, 1'b1, 0);
        check_eq("b2b_q2", 32'(q_a), 32'hEE);
        check_eq("b2b_valid2", 32'(valid_a), 32'h1);
        idle_cycle();
        check_eq("b2b_pulses", 32'(valid_cnt - base), 32'd2);

        // Reset mid-frame after three data bits
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        check_eq("mid_busy_before", 32'(busy_a), 32'h1);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_busy", 32'(busy_a), 32'h0);
        check_eq("mid_rst_q", 32'(q_a), 32'h0);
        idle_cycle();
        reset = 1'b0;
        base = valid_cnt;
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 0);
        check_eq("post_rst_q", 32'(q_a), 32'hC3);
        check_eq("post_rst_valid", 32'(valid_a), 32'h1);
        idle_cycle();
        idle_cycle();
        check_eq("post_rst_pulses", 32'(valid_cnt - base), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
